// File: rtl/lvt_pkg.sv
// rtl/lvt_pkg.sv - shared widths and read-response entry type for the LVT memory slice
package lvt_pkg;

  localparam int LVT_ADDR_W = 7;
  localparam int LVT_DATA_W = 7;

  typedef struct packed {
    logic [LVT_ADDR_W-1:0] addr;
    logic [LVT_DATA_W-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/lvt_rsp_fifo.sv
// rtl/lvt_rsp_fifo.sv - synchronous response FIFO of rd_entry_t with count, full and empty
module lvt_rsp_fifo
  import lvt_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  rd_entry_t        push_entry,
  input  logic             pop,
  output rd_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rd_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so outputs read as zero out of reset.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lvt_read_port.sv
// rtl/lvt_read_port.sv - in-order credit-protected read port with same-cycle write forwarding
module lvt_read_port
  import lvt_pkg::*;
#(
  parameter int ADDR_W = LVT_ADDR_W,
  parameter int DATA_W = LVT_DATA_W,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam int OCNT_W = $clog2(DEPTH + RD_LAT + 1) + 1;
  localparam int LAST = RD_LAT - 1;

  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_hit;
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic [DATA_W-1:0] pipe_data [RD_LAT];

  logic              issue;
  logic              hit0;
  logic              hit1;
  logic [DATA_W-1:0] fwd_data;
  logic [OCNT_W-1:0] outstanding;

  logic              push_req;
  logic              fifo_push;
  rd_entry_t         push_entry;
  rd_entry_t         fifo_head;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    outstanding = OCNT_W'(fifo_count);
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + OCNT_W'(pipe_vld[i]);
    end
  end

  assign req_ready   = (outstanding < OCNT_W'(DEPTH));
  assign issue       = req_valid && req_ready;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = req_addr;

  // Port 1 wins a double hit, mirroring the LVT write-1-wins rule.
  assign hit0     = wr0_en && (wr0_addr == req_addr);
  assign hit1     = wr1_en && (wr1_addr == req_addr);
  assign fwd_data = hit1 ? wr1_data : wr0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_hit[0]  <= hit0 || hit1;
    pipe_addr[0] <= req_addr;
    pipe_data[0] <= fwd_data;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_hit[i]  <= pipe_hit[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // Credits keep the FIFO from ever being full here; the guard only protects its state.
  assign push_req        = pipe_vld[LAST];
  assign fifo_push       = push_req && !fifo_full;
  assign push_entry.addr = pipe_addr[LAST];
  assign push_entry.data = pipe_hit[LAST] ? pipe_data[LAST] : mem_rd_data;

  lvt_rsp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_entry(push_entry),
    .pop       (rsp_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_head.data;
  assign rsp_addr  = fifo_head.addr;

endmodule

// File: tb/tb_lvt_read_port.sv
// tb/tb_lvt_read_port.sv - directed self-checking bench for lvt_read_port
module tb_lvt_read_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [6:0] rsp_data;
  logic [6:0] rsp_addr;
  logic       mem_rd_en;
  logic [6:0] mem_rd_addr;
  logic [6:0] mem_rd_data;
  logic       wr0_en;
  logic [6:0] wr0_addr;
  logic [6:0] wr0_data;
  logic       wr1_en;
  logic [6:0] wr1_addr;
  logic [6:0] wr1_data;

  int total = 0;
  int bad = 0;

  logic [6:0] mem [128];
  logic [6:0] rd_q = '0;

  always #5 clk = ~clk;

  lvt_read_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data)
  );

  // One-cycle read memory; a read sees the contents before a same-edge write.
  always @(posedge clk) begin
    if (mem_rd_en) rd_q <= mem[mem_rd_addr];
    if (wr0_en) mem[wr0_addr] <= wr0_data;
    if (wr1_en) mem[wr1_addr] <= wr1_data;
  end
  assign mem_rd_data = rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert (!(dut.push_req && dut.fifo_full)) else begin
        bad++;
        $error("FAIL push_when_full observed=1 expected=0");
      end
    end
  end

  function automatic logic [6:0] pat(input int i);
    return 7'((i * 5 + 3) & 127);
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0;
    wr0_en    = 1'b0;
    wr1_en    = 1'b0;
  endtask

  task automatic preload(input logic [6:0] a, input logic [6:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
    @(posedge clk); #1;
    wr0_en = 1'b0;
  endtask

  task automatic req(input string tag, input logic [6:0] a,
                     input logic w0, input logic [6:0] a0, input logic [6:0] d0,
                     input logic w1, input logic [6:0] a1, input logic [6:0] d1);
    req_valid = 1'b1; req_addr = a;
    wr0_en = w0; wr0_addr = a0; wr0_data = d0;
    wr1_en = w1; wr1_addr = a1; wr1_data = d1;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
    chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'(a));
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic expect_rsp(input string tag, input logic [6:0] a, input logic [6:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_addr"}, 32'(rsp_addr), 32'(a));
    chk({tag, "_data"}, 32'(rsp_data), 32'(d));
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req_addr = '0;
    wr0_addr = '0; wr0_data = '0;
    wr1_addr = '0; wr1_data = '0;
    idle_inputs();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    preload(7'd5, 7'h1A);
    preload(7'd9, 7'h03);
    preload(7'd12, 7'h33);
    preload(7'd20, 7'h44);
    rsp_ready = 1'b1;

    // basic read: response exactly two cycles after issue
    req("basic", 7'd5, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    @(negedge clk);
    chk("basic_not_early", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("basic_valid", 32'(rsp_valid), 32'd1);
    chk("basic_data", 32'(rsp_data), 32'h1A);
    chk("basic_addr", 32'(rsp_addr), 32'd5);
    @(posedge clk); #1;

    // same-cycle wr1 hazard, then a plain read one cycle later
    req("haz1", 7'd9, 1'b0, 7'd0, 7'd0, 1'b1, 7'd9, 7'h15);
    req("haz1b", 7'd9, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    expect_rsp("haz1_rsp", 7'd9, 7'h15);
    expect_rsp("haz1b_rsp", 7'd9, 7'h15);

    // both ports hit: wr1 wins; then wr0 alone
    req("dual", 7'd12, 1'b1, 7'd12, 7'h0A, 1'b1, 7'd12, 7'h0B);
    expect_rsp("dual_rsp", 7'd12, 7'h0B);
    req("wr0", 7'd12, 1'b1, 7'd12, 7'h0A, 1'b0, 7'd0, 7'd0);
    expect_rsp("wr0_rsp", 7'd12, 7'h0A);

    // writes to other addresses must not forward
    req("miss", 7'd20, 1'b1, 7'd21, 7'h11, 1'b1, 7'd22, 7'h22);
    expect_rsp("miss_rsp", 7'd20, 7'h44);

    for (int i = 0; i < 16; i++) preload(7'(i), pat(i));

    // backpressure: credits stop acceptance at four
    rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_addr = 7'(acc);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_head_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head_addr", 32'(rsp_addr), 32'd0);
    @(negedge clk);
    chk("bp_hold_addr", 32'(rsp_addr), 32'd0);
    chk("bp_hold_data", 32'(rsp_data), 32'(pat(0)));
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", 32'(rsp_valid), 32'd1);
      chk("bp_drain_addr", 32'(rsp_addr), 32'(i));
      chk("bp_drain_data", 32'(rsp_data), 32'(pat(i)));
      @(negedge clk);
    end
    chk("bp_empty", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // throughput: 16 back-to-back requests, 16 consecutive responses
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          req_valid = 1'b1;
          req_addr = 7'(i);
          @(negedge clk);
          chk("tp_ready", 32'(req_ready), 32'd1);
          @(posedge clk); #1;
        end
        idle_inputs();
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
          n++;
          @(negedge clk);
        end
        for (int k = 0; k < 16; k++) begin
          if (k > 0) @(negedge clk);
          chk("tp_valid", 32'(rsp_valid), 32'd1);
          chk("tp_addr", 32'(rsp_addr), 32'(k));
          chk("tp_data", 32'(rsp_data), 32'(pat(k)));
        end
      end
    join
    @(negedge clk);
    chk("tp_drained", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // reset mid-operation discards buffered and in-flight reads
    rsp_ready = 1'b0;
    req("pre_rst_a", 7'd1, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    req("pre_rst_b", 7'd2, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    req("pre_rst_c", 7'd3, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_data", 32'(rsp_data), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    end
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req("post_rst_req", 7'd2, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    expect_rsp("post_rst_rsp", 7'd2, pat(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
